// File: rtl/debug_uart_tx.sv
// ---------------------------------------------------------------------------
// debug_uart_tx
//
// Serial transmit stage for the debug controller. When tx_flag is seen high
// in IDLE, the 32-bit word on data_internal is captured and sent LSB-byte
// first as four UART characters: data[7:0], data[15:8], data[23:16],
// data[31:24]. Bytes follow each other with no idle gap. When the last stop
// bit ends, doneSending pulses for one cycle. The block then waits for
// tx_flag to go low before it will accept another request.
//
// Character format:
//   default                 : 8N1 (start, 8 data LSB first, stop)
//   `define DEBUG_TX_PARITY_EN : 8E1 (even parity bit between bit 7 and stop)
//
// Parameters:
//   freq  system clock frequency in Hz
//   baud  line rate; CLKS_PER_BIT = freq/baud must be >= 2
//
// Ports:
//   CLK            in   system clock, rising edge
//   RST            in   asynchronous active-low reset
//   tx_flag        in   transmit request level from the debug controller
//   data_internal  in   [31:0] word to send, sampled only at trigger
//   tx             out  UART serial line, idle high, driven from a flop
//   busy           out  high from trigger until doneSending is issued
//   doneSending    out  one-cycle pulse when the frame is complete
// ---------------------------------------------------------------------------
module debug_uart_tx #(
    parameter int freq = 50000000,
    parameter int baud = 115200
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        tx_flag,
    input  logic [31:0] data_internal,
    output logic        tx,
    output logic        busy,
    output logic        doneSending
);

    localparam int CLKS_PER_BIT = freq / baud;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef DEBUG_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE, WAIT_LOW} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE, WAIT_LOW} state_t;
`endif

    state_t             state_q,    state_d;
    logic [CNT_W-1:0]   clk_cnt_q,  clk_cnt_d;
    logic [2:0]         bit_idx_q,  bit_idx_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [31:0]        shift_q,    shift_d;
    logic               tx_q,       tx_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;

    logic               bit_end;
    logic [7:0]         cur_byte;

    // NOTE: every signal written in this block gets a default first, so no
    // path through the case statements can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        bit_end    = (clk_cnt_q == CNT_LAST);

        unique case (state_q)
            IDLE: begin
                if (tx_flag) begin
                    shift_d    = data_internal;
                    byte_idx_d = '0;
                    bit_idx_d  = '0;
                    clk_cnt_d  = '0;
                    state_d    = START;
                end
            end
            START: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
`ifdef DEBUG_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
`ifdef DEBUG_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    state_d   = STOP;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    if (byte_idx_q != 2'd3) begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        state_d    = START;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                // Controller drops tx_flag only after seeing doneSending;
                // holding here keeps that trailing high level from retriggering.
                if (!tx_flag) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are computed from the next-state values so the registered
        // tx changes in the same cycle the state does (1-cycle trigger latency).
        unique case (byte_idx_d)
            2'd0:    cur_byte = shift_q[7:0];
            2'd1:    cur_byte = shift_q[15:8];
            2'd2:    cur_byte = shift_q[23:16];
            default: cur_byte = shift_q[31:24];
        endcase

        tx_d = 1'b1;
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = cur_byte[bit_idx_d];
`ifdef DEBUG_TX_PARITY_EN
            PARITY:  tx_d = ^cur_byte;
`endif
            default: tx_d = 1'b1;
        endcase

`ifdef DEBUG_TX_PARITY_EN
        busy_d = (state_d == START) || (state_d == DATA) ||
                 (state_d == PARITY) || (state_d == STOP);
`else
        busy_d = (state_d == START) || (state_d == DATA) || (state_d == STOP);
`endif
        done_d = (state_d == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            // NOTE: the shift register is only a 32-bit holding register, so
            // it is reset with everything else; large RAM arrays would not be.
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx          = tx_q;
    assign busy        = busy_q;
    assign doneSending = done_q;

endmodule
